// File: rtl/pipeline_types.sv
// rtl/pipeline_types.sv - shared execute-pipeline types: bus widths and divider FSM states
package pipeline_types;

  typedef logic [31:0] bus32_t;
  typedef logic [63:0] bus64_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Two's-complement magnitude; 0x80000000 maps onto itself, which is its unsigned magnitude.
  function automatic bus32_t abs32(input bus32_t v, input logic neg);
    return neg ? bus32_t'(~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/clz32.sv
// rtl/clz32.sv - 32-bit leading-zero counter; an all-zero input yields 32
module clz32 (
  input  logic [31:0] i_data,
  output logic [5:0]  o_clz
);

  always_comb begin
    o_clz = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (i_data[i]) o_clz = 6'(31 - i);
    end
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider, signed/unsigned, one quotient bit per cycle
// Optional DIV_EARLY_OUT_EN: skips leading-zero iterations of the dividend via clz32.
module div_unit
  import pipeline_types::*;
#(
  parameter int DIV_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   div_flush,
  input  logic [DIV_WIDTH-1:0]   div_data1,
  input  logic [DIV_WIDTH-1:0]   div_data2,
  input  logic                   div_signed,
  input  logic                   div_start,
  output logic [2*DIV_WIDTH-1:0] div_result,
  output logic                   div_done
);

  localparam int                CNT_W    = 6;
  localparam logic [CNT_W-1:0]  LAST_CNT = 6'd31;

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  bus32_t           r_rem;
  bus32_t           r_dvd;
  bus32_t           r_dvs;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_done;
  bus64_t           r_result;

  logic             w_s1;
  logic             w_s2;
  bus32_t           w_abs1;
  bus32_t           w_abs2;
  logic             w_start;
  bus32_t           w_dvd_init;
  logic [CNT_W-1:0] w_cnt_init;
  logic [32:0]      w_rem_sh;
  logic             w_ge;
  bus32_t           w_rem_nxt;
  bus32_t           w_dvd_nxt;
  bus32_t           w_quo_fix;
  bus32_t           w_rem_fix;

  assign w_s1   = div_signed & div_data1[31];
  assign w_s2   = div_signed & div_data2[31];
  assign w_abs1 = abs32(div_data1, w_s1);
  assign w_abs2 = abs32(div_data2, w_s2);

  // The done-pulse cycle still belongs to the finished operation, so a start held there is ignored.
  assign w_start = div_start & ~div_flush & ~r_done;

`ifdef DIV_EARLY_OUT_EN
  logic [5:0] w_clz;

  clz32 u_clz (
    .i_data (w_abs1),
    .o_clz  (w_clz)
  );

  // Leading zeros only produce zero quotient bits, so start the counter past them.
  assign w_dvd_init = w_clz[5] ? '0 : (w_abs1 << w_clz[4:0]);
  assign w_cnt_init = w_clz[5] ? LAST_CNT : w_clz;
`else
  assign w_dvd_init = w_abs1;
  assign w_cnt_init = '0;
`endif

  assign w_rem_sh  = {r_rem, r_dvd[31]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? (w_rem_sh[31:0] - r_dvs) : w_rem_sh[31:0];
  assign w_dvd_nxt = {r_dvd[30:0], w_ge};

  assign w_quo_fix = r_q_neg ? bus32_t'(~r_dvd + 32'd1) : r_dvd;
  assign w_rem_fix = r_r_neg ? bus32_t'(~r_rem + 32'd1) : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (div_flush) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start) begin
              r_dvs <= w_abs2;
              if (div_data2 == '0) begin
                // Divide-by-zero returns the raw dividend as remainder, uncorrected.
                r_rem   <= div_data1;
                r_dvd   <= '1;
                r_q_neg <= 1'b0;
                r_r_neg <= 1'b0;
                r_state <= DONE;
              end else begin
                r_rem   <= '0;
                r_dvd   <= w_dvd_init;
                r_cnt   <= w_cnt_init;
                r_q_neg <= w_s1 ^ w_s2;
                r_r_neg <= w_s1;
                r_state <= DIV;
              end
            end
          end
          DIV: begin
            r_rem <= w_rem_nxt;
            r_dvd <= w_dvd_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) r_state <= DONE;
          end
          DONE: begin
            r_done   <= 1'b1;
            r_result <= {w_rem_fix, w_quo_fix};
            r_state  <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign div_done   = r_done;
  assign div_result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed vector bench for div_unit (latency follows DIV_EARLY_OUT_EN)
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        div_flush;
  logic [31:0] div_data1;
  logic [31:0] div_data2;
  logic        div_signed;
  logic        div_start;
  logic [63:0] div_result;
  logic        div_done;

  int n_vec;
  int n_miss;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        sg;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[13];

  div_unit #(.DIV_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_flush  (div_flush),
    .div_data1  (div_data1),
    .div_data2  (div_data2),
    .div_signed (div_signed),
    .div_start  (div_start),
    .div_result (div_result),
    .div_done   (div_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] d1, input logic [31:0] d2, input logic sg);
    int n;
    logic [31:0] a;
    if (d2 == 32'd0) return 1;
    n = 32;
`ifdef DIV_EARLY_OUT_EN
    a = (sg && d1[31]) ? (32'd0 - d1) : d1;
    n = 1;
    for (int i = 0; i < 32; i++) if (a[i]) n = i + 1;
`else
    a = d1;
`endif
    return 1 + n;
  endfunction

  task automatic run_op(input logic [31:0] d1, input logic [31:0] d2, input logic sg,
                        output logic [63:0] res, output int lat);
    @(negedge clk);
    div_data1 = d1; div_data2 = d2; div_signed = sg; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (div_done) begin lat = c; break; end
    end
    res = div_result;
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (div_done) cnt++;
    end
  endtask

  initial begin
    logic [63:0] res;
    int lat;
    int cnt;

    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; div_flush = 1'b0; div_start = 1'b0;
    div_data1 = '0; div_data2 = '0; div_signed = 1'b0;

    vecs[0]  = '{32'd100,      32'd7,          1'b0, {32'd2,          32'd14}};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,          1'b1, {32'hFFFFFFFF,   32'hFFFFFFFD}};
    vecs[2]  = '{32'hFFFFFFF9, 32'd2,          1'b0, {32'd1,          32'h7FFFFFFC}};
    vecs[3]  = '{32'h12345678, 32'd0,          1'b1, {32'h12345678,   32'hFFFFFFFF}};
    vecs[4]  = '{32'h12345678, 32'd0,          1'b0, {32'h12345678,   32'hFFFFFFFF}};
    vecs[5]  = '{32'h80000000, 32'hFFFFFFFF,   1'b1, {32'd0,          32'h80000000}};
    vecs[6]  = '{32'd5,        32'd3,          1'b0, {32'd2,          32'd1}};
    vecs[7]  = '{32'd0,        32'd7,          1'b0, {32'd0,          32'd0}};
    vecs[8]  = '{32'hFFFFFFFF, 32'd1,          1'b0, {32'd0,          32'hFFFFFFFF}};
    vecs[9]  = '{32'hFFFFFF9C, 32'd7,          1'b1, {32'hFFFFFFFE,   32'hFFFFFFF2}};
    vecs[10] = '{32'd100,      32'hFFFFFFF9,   1'b1, {32'd2,          32'hFFFFFFF2}};
    vecs[11] = '{32'd7,        32'd100,        1'b0, {32'd7,          32'd0}};
    vecs[12] = '{32'h80000000, 32'd2,          1'b1, {32'd0,          32'hC0000000}};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", {63'd0, div_done}, 64'd0);
    chk("reset_result", div_result, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].d1, vecs[i].d2, vecs[i].sg, res, lat);
      chk($sformatf("v%0d_result", i), res, vecs[i].exp);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].d1, vecs[i].d2, vecs[i].sg)));
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse_width", i), {63'd0, div_done}, 64'd0);
      chk($sformatf("v%0d_hold", i), div_result, vecs[i].exp);
    end

    // start held high through DIV: single done pulse, operands not re-sampled
    @(negedge clk);
    div_data1 = 32'h80000000; div_data2 = 32'hFFFFFFFF; div_signed = 1'b1; div_start = 1'b1;
    @(posedge clk); #1;
    div_data1 = 32'd50; div_data2 = 32'd5;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (div_done) begin lat = c; div_start = 1'b0; break; end
    end
    div_start = 1'b0;
    chk("held_start_latency", 64'(lat), 64'(exp_lat(32'h80000000, 32'hFFFFFFFF, 1'b1)));
    chk("held_start_result", div_result, {32'd0, 32'h80000000});
    count_dones(45, cnt);
    chk("held_start_single_done", 64'(cnt), 64'd0);

    // flush 10 cycles into 1000/3 kills the operation
    @(negedge clk);
    div_data1 = 32'd1000; div_data2 = 32'd3; div_signed = 1'b0; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    count_dones(10, cnt);
    div_flush = 1'b1;
    @(posedge clk); #1;
    div_flush = 1'b0;
    if (div_done) cnt++;
    begin
      int cnt2;
      count_dones(45, cnt2);
      cnt += cnt2;
    end
    chk("flush_no_done", 64'(cnt), 64'd0);
    chk("flush_result_held", div_result, {32'd0, 32'h80000000});
    run_op(32'd9, 32'd4, 1'b0, res, lat);
    chk("after_flush_result", res, {32'd1, 32'd2});
    chk("after_flush_latency", 64'(lat), 64'(exp_lat(32'd9, 32'd4, 1'b0)));

    // flush landing on the DONE cycle of a divide-by-zero
    @(negedge clk);
    div_data1 = 32'd5; div_data2 = 32'd0; div_signed = 1'b0; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0; div_flush = 1'b1;
    @(posedge clk); #1;
    div_flush = 1'b0;
    cnt = div_done ? 1 : 0;
    chk("flush_at_done_no_pulse", 64'(cnt), 64'd0);
    count_dones(5, cnt);
    chk("flush_at_done_later", 64'(cnt), 64'd0);
    chk("flush_at_done_result", div_result, {32'd1, 32'd2});

    // asynchronous reset mid-DIV
    @(negedge clk);
    div_data1 = 32'd1000; div_data2 = 32'd3; div_signed = 1'b0; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_result", div_result, 64'd0);
    chk("async_reset_done", {63'd0, div_done}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    count_dones(40, cnt);
    chk("reset_abort_no_done", 64'(cnt), 64'd0);
    run_op(32'd1000, 32'd3, 1'b0, res, lat);
    chk("after_reset_result", res, {32'd1, 32'd333});
    chk("after_reset_latency", 64'(lat), 64'(exp_lat(32'd1000, 32'd3, 1'b0)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
